// File: rtl/ysyx_22040088_mem_arbiter.sv
// IFU/LSU arbiter for the single downstream memory port.
// One outstanding transaction, registered grant, response watchdog.
module ysyx_22040088_mem_arbiter #(
    parameter int          LSU_PRIO = 1,
    parameter int unsigned TIMEOUT  = 255,
    parameter int unsigned CNT_W    = 8
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        ifu_req_valid,
    output logic        ifu_req_ready,
    input  logic [63:0] ifu_addr,
    output logic        ifu_resp_valid,
    output logic [63:0] ifu_rdata,
    output logic        ifu_resp_err,

    input  logic        lsu_req_valid,
    output logic        lsu_req_ready,
    input  logic [63:0] lsu_addr,
    input  logic        lsu_wen,
    input  logic [63:0] lsu_wdata,
    input  logic [7:0]  lsu_wmask,
    output logic        lsu_resp_valid,
    output logic [63:0] lsu_rdata,
    output logic        lsu_resp_err,

    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [63:0] mem_addr,
    output logic        mem_wen,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    input  logic        mem_resp_valid,
    input  logic [63:0] mem_rdata,

    output logic        arb_busy,
    output logic        err_unexp
);

    typedef enum logic [1:0] {
        IDLE,
        GNT_IF,
        GNT_LS,
        WAIT_RESP
    } state_t;

    typedef enum logic {
        OWN_IF,
        OWN_LS
    } owner_t;

    localparam bit WDOG_EN = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] WDOG_LAST =
        WDOG_EN ? CNT_W'(TIMEOUT - 1) : '0;

    state_t           state;
    state_t           state_nxt;
    owner_t           owner;
    owner_t           owner_nxt;
    owner_t           last_grant;
    owner_t           last_grant_nxt;
    logic [CNT_W-1:0] wdog;
    logic [CNT_W-1:0] wdog_nxt;

    logic             resp_fire;
    logic             resp_err;
    logic [63:0]      resp_data;
    logic             pick_ls;

    // Round-robin favours whoever did not win last time.
    assign pick_ls = (LSU_PRIO != 0) || (last_grant == OWN_IF);

    always_comb begin
        state_nxt      = state;
        owner_nxt      = owner;
        last_grant_nxt = last_grant;
        wdog_nxt       = wdog;

        mem_req_valid  = 1'b0;
        mem_addr       = '0;
        mem_wen        = 1'b0;
        mem_wdata      = '0;
        mem_wmask      = '0;
        ifu_req_ready  = 1'b0;
        lsu_req_ready  = 1'b0;

        resp_fire      = 1'b0;
        resp_err       = 1'b0;
        resp_data      = '0;

        if (!rst) begin
            unique case (state)
                IDLE: begin
                    if (ifu_req_valid && lsu_req_valid) begin
                        if (pick_ls) begin
                            state_nxt      = GNT_LS;
                            owner_nxt      = OWN_LS;
                            last_grant_nxt = OWN_LS;
                        end else begin
                            state_nxt      = GNT_IF;
                            owner_nxt      = OWN_IF;
                            last_grant_nxt = OWN_IF;
                        end
                    end else if (ifu_req_valid) begin
                        state_nxt      = GNT_IF;
                        owner_nxt      = OWN_IF;
                        last_grant_nxt = OWN_IF;
                    end else if (lsu_req_valid) begin
                        state_nxt      = GNT_LS;
                        owner_nxt      = OWN_LS;
                        last_grant_nxt = OWN_LS;
                    end
                end

                GNT_IF: begin
                    mem_req_valid = ifu_req_valid;
                    mem_addr      = ifu_addr;
                    ifu_req_ready = ifu_req_valid && mem_req_ready;
                    if (ifu_req_ready) begin
                        state_nxt = WAIT_RESP;
                        wdog_nxt  = '0;
                    end
                end

                GNT_LS: begin
                    mem_req_valid = lsu_req_valid;
                    mem_addr      = lsu_addr;
                    mem_wen       = lsu_wen;
                    mem_wdata     = lsu_wdata;
                    mem_wmask     = lsu_wmask;
                    lsu_req_ready = lsu_req_valid && mem_req_ready;
                    if (lsu_req_ready) begin
                        state_nxt = WAIT_RESP;
                        wdog_nxt  = '0;
                    end
                end

                WAIT_RESP: begin
                    // A real response beats a timeout in the same cycle.
                    if (mem_resp_valid) begin
                        resp_fire = 1'b1;
                        resp_data = mem_rdata;
                        state_nxt = IDLE;
                    end else if (WDOG_EN && (wdog == WDOG_LAST)) begin
                        resp_fire = 1'b1;
                        resp_err  = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        wdog_nxt = wdog + CNT_W'(1);
                    end
                end

                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    assign ifu_resp_valid = resp_fire && (owner == OWN_IF);
    assign ifu_resp_err   = resp_err && (owner == OWN_IF);
    assign ifu_rdata      = (owner == OWN_IF) ? resp_data : '0;

    assign lsu_resp_valid = resp_fire && (owner == OWN_LS);
    assign lsu_resp_err   = resp_err && (owner == OWN_LS);
    assign lsu_rdata      = (owner == OWN_LS) ? resp_data : '0;

    assign arb_busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= OWN_IF;
            last_grant <= OWN_LS;
            wdog       <= '0;
            err_unexp  <= 1'b0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            last_grant <= last_grant_nxt;
            wdog       <= wdog_nxt;
            if (mem_resp_valid && (state != WAIT_RESP)) begin
                err_unexp <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_22040088_mem_arbiter.sv
// Directed scoreboard bench for the IFU/LSU memory arbiter.
// Instance 0 uses LSU priority, instance 1 round-robin; both TIMEOUT=4.
`timescale 1ns/1ps
module tb_ysyx_22040088_mem_arbiter;

    localparam int N = 2;

    localparam int K_CTRL  = 0;
    localparam int K_BUSY  = 1;
    localparam int K_UNEXP = 2;
    localparam int K_ADDR  = 3;
    localparam int K_WDATA = 4;
    localparam int K_WCTL  = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        ifu_req_valid  [N];
    logic        ifu_req_ready  [N];
    logic [63:0] ifu_addr       [N];
    logic        ifu_resp_valid [N];
    logic [63:0] ifu_rdata      [N];
    logic        ifu_resp_err   [N];
    logic        lsu_req_valid  [N];
    logic        lsu_req_ready  [N];
    logic [63:0] lsu_addr       [N];
    logic        lsu_wen        [N];
    logic [63:0] lsu_wdata      [N];
    logic [7:0]  lsu_wmask      [N];
    logic        lsu_resp_valid [N];
    logic [63:0] lsu_rdata      [N];
    logic        lsu_resp_err   [N];
    logic        mem_req_valid  [N];
    logic        mem_req_ready  [N];
    logic [63:0] mem_addr       [N];
    logic        mem_wen        [N];
    logic [63:0] mem_wdata      [N];
    logic [7:0]  mem_wmask      [N];
    logic        mem_resp_valid [N];
    logic [63:0] mem_rdata      [N];
    logic        arb_busy       [N];
    logic        err_unexp      [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        ysyx_22040088_mem_arbiter #(
            .LSU_PRIO((g == 0) ? 1 : 0),
            .TIMEOUT (4),
            .CNT_W   (8)
        ) dut (
            .clk           (clk),
            .rst           (rst),
            .ifu_req_valid (ifu_req_valid[g]),
            .ifu_req_ready (ifu_req_ready[g]),
            .ifu_addr      (ifu_addr[g]),
            .ifu_resp_valid(ifu_resp_valid[g]),
            .ifu_rdata     (ifu_rdata[g]),
            .ifu_resp_err  (ifu_resp_err[g]),
            .lsu_req_valid (lsu_req_valid[g]),
            .lsu_req_ready (lsu_req_ready[g]),
            .lsu_addr      (lsu_addr[g]),
            .lsu_wen       (lsu_wen[g]),
            .lsu_wdata     (lsu_wdata[g]),
            .lsu_wmask     (lsu_wmask[g]),
            .lsu_resp_valid(lsu_resp_valid[g]),
            .lsu_rdata     (lsu_rdata[g]),
            .lsu_resp_err  (lsu_resp_err[g]),
            .mem_req_valid (mem_req_valid[g]),
            .mem_req_ready (mem_req_ready[g]),
            .mem_addr      (mem_addr[g]),
            .mem_wen       (mem_wen[g]),
            .mem_wdata     (mem_wdata[g]),
            .mem_wmask     (mem_wmask[g]),
            .mem_resp_valid(mem_resp_valid[g]),
            .mem_rdata     (mem_rdata[g]),
            .arb_busy      (arb_busy[g]),
            .err_unexp     (err_unexp[g])
        );
    end

    typedef struct {
        int          inst;
        bit          lsu;
        logic [63:0] addr;
        bit          wen;
        logic [63:0] wdata;
        logic [7:0]  wmask;
        int          cyc;
    } req_t;

    typedef struct {
        int          inst;
        bit          lsu;
        logic [63:0] rdata;
        bit          err;
        int          cyc;
    } resp_t;

    typedef struct {
        int          inst;
        int          kind;
        logic [63:0] exp;
        int          cyc;
    } probe_t;

    req_t   req_q   [$];
    resp_t  resp_q  [$];
    probe_t probe_q [$];

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    bit done       = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_req(input int g, input bit lsu, input logic [63:0] a,
                           input bit w, input logic [63:0] d,
                           input logic [7:0] m);
        req_q.push_back('{g, lsu, a, w, d, m, cyc});
    endtask

    task automatic exp_resp(input int g, input bit lsu, input logic [63:0] d,
                            input bit e, input int at);
        resp_q.push_back('{g, lsu, d, e, at});
    endtask

    task automatic probe(input int g, input int kind, input logic [63:0] v);
        probe_q.push_back('{g, kind, v, cyc});
    endtask

    task automatic set_ifu(input int g, input bit v, input logic [63:0] a);
        ifu_req_valid[g] = v;
        ifu_addr[g]      = a;
    endtask

    task automatic set_lsu(input int g, input bit v, input logic [63:0] a,
                           input bit w, input logic [63:0] d,
                           input logic [7:0] m);
        lsu_req_valid[g] = v;
        lsu_addr[g]      = a;
        lsu_wen[g]       = w;
        lsu_wdata[g]     = d;
        lsu_wmask[g]     = m;
    endtask

    // Called in a GNT cycle: handshake now, response on the next cycle.
    task automatic serve(input int g, input bit lsu, input logic [63:0] a,
                         input bit w, input logic [63:0] d,
                         input logic [7:0] m, input logic [63:0] rd);
        mem_req_ready[g] = 1'b1;
        exp_req(g, lsu, a, w, d, m);
        probe(g, K_BUSY, 64'd1);
        tick();
        mem_req_ready[g] = 1'b0;
        if (lsu) lsu_req_valid[g] = 1'b0;
        else     ifu_req_valid[g] = 1'b0;
        mem_resp_valid[g] = 1'b1;
        mem_rdata[g]      = rd;
        exp_resp(g, lsu, rd, 1'b0, cyc);
        tick();
        mem_resp_valid[g] = 1'b0;
        mem_rdata[g]      = '0;
        probe(g, K_CTRL, 64'd0);
        probe(g, K_BUSY, 64'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin : stim
        rst = 1'b1;
        for (int g = 0; g < N; g++) begin
            set_ifu(g, 1'b0, '0);
            set_lsu(g, 1'b0, '0, 1'b0, '0, '0);
            mem_req_ready[g]  = 1'b0;
            mem_resp_valid[g] = 1'b0;
            mem_rdata[g]      = '0;
        end
        tick();
        tick();
        rst = 1'b0;
        for (int g = 0; g < N; g++) begin
            probe(g, K_CTRL, 64'd0);
            probe(g, K_BUSY, 64'd0);
            probe(g, K_UNEXP, 64'd0);
        end
        tick();

        // Single IFU fetch.
        set_ifu(0, 1'b1, 64'h8000_0000);
        probe(0, K_CTRL, 64'd0);
        tick();
        serve(0, 1'b0, 64'h8000_0000, 1'b0, '0, '0, 64'h13);

        // LSU store with downstream stalled for three cycles.
        set_lsu(0, 1'b1, 64'h8000_1000, 1'b1, 64'hDEAD_BEEF, 8'h0F);
        tick();
        for (int i = 0; i < 3; i++) begin
            probe(0, K_CTRL, 64'h40);
            probe(0, K_ADDR, 64'h8000_1000);
            probe(0, K_WDATA, 64'hDEAD_BEEF);
            probe(0, K_WCTL, 64'h10F);
            tick();
        end
        serve(0, 1'b1, 64'h8000_1000, 1'b1, 64'hDEAD_BEEF, 8'h0F, 64'h0);

        // Conflict on the LSU-priority instance: LSU, then IFU.
        set_ifu(0, 1'b1, 64'h8000_0100);
        set_lsu(0, 1'b1, 64'h8000_2000, 1'b1, 64'h1111, 8'hFF);
        tick();
        serve(0, 1'b1, 64'h8000_2000, 1'b1, 64'h1111, 8'hFF, 64'hA1);
        tick();
        serve(0, 1'b0, 64'h8000_0100, 1'b0, '0, '0, 64'hB2);

        // LSU keeps winning while it keeps requesting.
        set_ifu(0, 1'b1, 64'h8000_0104);
        set_lsu(0, 1'b1, 64'h8000_2008, 1'b0, 64'h2222, 8'hF0);
        tick();
        serve(0, 1'b1, 64'h8000_2008, 1'b0, 64'h2222, 8'hF0, 64'hC3);
        set_lsu(0, 1'b1, 64'h8000_2010, 1'b1, 64'h3333, 8'h03);
        tick();
        serve(0, 1'b1, 64'h8000_2010, 1'b1, 64'h3333, 8'h03, 64'hD4);
        tick();
        serve(0, 1'b0, 64'h8000_0104, 1'b0, '0, '0, 64'hE5);

        // Response lands exactly on the watchdog cycle.
        set_ifu(0, 1'b1, 64'h8000_0200);
        tick();
        mem_req_ready[0] = 1'b1;
        exp_req(0, 1'b0, 64'h8000_0200, 1'b0, '0, '0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            mem_req_ready[0] = 1'b0;
            ifu_req_valid[0] = 1'b0;
            mem_rdata[0]     = 64'hFFFF_FFFF_FFFF_FFFF;
            if (k == 4) begin
                mem_resp_valid[0] = 1'b1;
                mem_rdata[0]      = 64'h1234_5678_9ABC_DEF0;
                exp_resp(0, 1'b0, 64'h1234_5678_9ABC_DEF0, 1'b0, cyc);
            end
        end
        tick();
        mem_resp_valid[0] = 1'b0;
        mem_rdata[0]      = '0;
        probe(0, K_UNEXP, 64'd0);
        probe(0, K_BUSY, 64'd0);

        // LSU read times out; a late response is flagged, not forwarded.
        set_lsu(0, 1'b1, 64'h8000_3000, 1'b0, '0, '0);
        tick();
        mem_req_ready[0] = 1'b1;
        exp_req(0, 1'b1, 64'h8000_3000, 1'b0, '0, '0);
        tick();
        mem_req_ready[0] = 1'b0;
        lsu_req_valid[0] = 1'b0;
        mem_rdata[0]     = 64'hA5A5_A5A5_A5A5_A5A5;
        exp_resp(0, 1'b1, 64'h0, 1'b1, cyc + 3);
        probe(0, K_BUSY, 64'd1);
        tick();
        tick();
        tick();
        tick();
        mem_resp_valid[0] = 1'b1;
        mem_rdata[0]      = 64'h77;
        probe(0, K_CTRL, 64'd0);
        probe(0, K_UNEXP, 64'd0);
        tick();
        mem_resp_valid[0] = 1'b0;
        mem_rdata[0]      = '0;
        probe(0, K_UNEXP, 64'd1);
        probe(0, K_BUSY, 64'd0);

        // Reset while waiting for a response.
        set_ifu(0, 1'b1, 64'h8000_0400);
        tick();
        mem_req_ready[0] = 1'b1;
        exp_req(0, 1'b0, 64'h8000_0400, 1'b0, '0, '0);
        tick();
        mem_req_ready[0]  = 1'b0;
        ifu_req_valid[0]  = 1'b0;
        rst               = 1'b1;
        mem_resp_valid[0] = 1'b1;
        mem_rdata[0]      = 64'h99;
        probe(0, K_CTRL, 64'd0);
        tick();
        rst = 1'b0;
        probe(0, K_BUSY, 64'd0);
        probe(0, K_UNEXP, 64'd0);
        probe(0, K_CTRL, 64'd0);
        tick();
        mem_resp_valid[0] = 1'b0;
        mem_rdata[0]      = '0;
        probe(0, K_UNEXP, 64'd1);
        set_ifu(0, 1'b1, 64'h8000_0408);
        tick();
        serve(0, 1'b0, 64'h8000_0408, 1'b0, '0, '0, 64'h55);

        // Round-robin instance: IFU first, then alternating.
        set_ifu(1, 1'b1, 64'h8000_0500);
        set_lsu(1, 1'b1, 64'h8000_4000, 1'b1, 64'h4444, 8'hCC);
        tick();
        serve(1, 1'b0, 64'h8000_0500, 1'b0, '0, '0, 64'h61);
        set_ifu(1, 1'b1, 64'h8000_0504);
        tick();
        serve(1, 1'b1, 64'h8000_4000, 1'b1, 64'h4444, 8'hCC, 64'h62);
        set_lsu(1, 1'b1, 64'h8000_4008, 1'b0, 64'h5555, 8'h33);
        tick();
        serve(1, 1'b0, 64'h8000_0504, 1'b0, '0, '0, 64'h63);
        tick();
        serve(1, 1'b1, 64'h8000_4008, 1'b0, 64'h5555, 8'h33, 64'h64);

        tick();
        done = 1'b1;
    end

    // ---------------- monitor / scoreboard ----------------
    function automatic logic [63:0] sample(input int g, input int kind);
        logic [63:0] v;
        v = '0;
        case (kind)
            K_CTRL:  v = {57'd0, mem_req_valid[g], ifu_req_ready[g],
                          lsu_req_ready[g], ifu_resp_valid[g],
                          ifu_resp_err[g], lsu_resp_valid[g],
                          lsu_resp_err[g]};
            K_BUSY:  v = {63'd0, arb_busy[g]};
            K_UNEXP: v = {63'd0, err_unexp[g]};
            K_ADDR:  v = mem_addr[g];
            K_WDATA: v = mem_wdata[g];
            K_WCTL:  v = {55'd0, mem_wen[g], mem_wmask[g]};
            default: v = '1;
        endcase
        return v;
    endfunction

    always @(negedge clk) begin : mon
        req_t        r;
        resp_t       p;
        probe_t      pr;
        logic [63:0] act;
        bit          al;
        logic [63:0] ad;
        logic        ae;

        for (int g = 0; g < N; g++) begin
            if (mem_req_valid[g] && mem_req_ready[g]) begin
                compared++;
                if (req_q.size() == 0) begin
                    mismatched++;
                    $display("FAIL req_unexp inst=%0d cyc=%0d addr=%h",
                             g, cyc, mem_addr[g]);
                end else begin
                    r = req_q.pop_front();
                    if (r.inst != g || r.cyc != cyc ||
                        mem_addr[g] !== r.addr || mem_wen[g] !== r.wen ||
                        mem_wdata[g] !== r.wdata ||
                        mem_wmask[g] !== r.wmask ||
                        ifu_req_ready[g] !== !r.lsu ||
                        lsu_req_ready[g] !== r.lsu) begin
                        mismatched++;
                        $display({"FAIL req inst=%0d cyc=%0d got addr=%h wen=%b ",
                                  "wdata=%h wmask=%h rdy_if=%b rdy_ls=%b need ",
                                  "inst=%0d cyc=%0d addr=%h wen=%b wdata=%h ",
                                  "wmask=%h lsu=%b"},
                                 g, cyc, mem_addr[g], mem_wen[g],
                                 mem_wdata[g], mem_wmask[g],
                                 ifu_req_ready[g], lsu_req_ready[g],
                                 r.inst, r.cyc, r.addr, r.wen, r.wdata,
                                 r.wmask, r.lsu);
                    end
                end
            end else if (ifu_req_ready[g] || lsu_req_ready[g]) begin
                compared++;
                mismatched++;
                $display("FAIL ready_spurious inst=%0d cyc=%0d got if=%b ls=%b need 0 0",
                         g, cyc, ifu_req_ready[g], lsu_req_ready[g]);
            end

            if (ifu_resp_valid[g] || lsu_resp_valid[g]) begin
                compared++;
                al = lsu_resp_valid[g];
                ad = al ? lsu_rdata[g] : ifu_rdata[g];
                ae = al ? lsu_resp_err[g] : ifu_resp_err[g];
                if (resp_q.size() == 0) begin
                    mismatched++;
                    $display("FAIL resp_unexp inst=%0d cyc=%0d lsu=%b rdata=%h err=%b",
                             g, cyc, al, ad, ae);
                end else begin
                    p = resp_q.pop_front();
                    if (p.inst != g || p.cyc != cyc ||
                        (ifu_resp_valid[g] && lsu_resp_valid[g]) ||
                        al != p.lsu || ad !== p.rdata || ae !== p.err) begin
                        mismatched++;
                        $display({"FAIL resp inst=%0d cyc=%0d got if=%b ls=%b ",
                                  "rdata=%h err=%b need inst=%0d cyc=%0d ",
                                  "lsu=%b rdata=%h err=%b"},
                                 g, cyc, ifu_resp_valid[g], lsu_resp_valid[g],
                                 ad, ae, p.inst, p.cyc, p.lsu, p.rdata, p.err);
                    end
                end
            end
        end

        while (req_q.size() > 0 && req_q[0].cyc <= cyc) begin
            r = req_q.pop_front();
            compared++;
            mismatched++;
            $display("FAIL req_missing inst=%0d cyc=%0d got none need addr=%h",
                     r.inst, r.cyc, r.addr);
        end

        while (resp_q.size() > 0 && resp_q[0].cyc <= cyc) begin
            p = resp_q.pop_front();
            compared++;
            mismatched++;
            $display("FAIL resp_missing inst=%0d cyc=%0d got none need rdata=%h err=%b",
                     p.inst, p.cyc, p.rdata, p.err);
        end

        while (probe_q.size() > 0 && probe_q[0].cyc <= cyc) begin
            pr  = probe_q.pop_front();
            act = sample(pr.inst, pr.kind);
            compared++;
            if (pr.cyc != cyc || act !== pr.exp) begin
                mismatched++;
                $display("FAIL probe kind=%0d inst=%0d cyc=%0d got %h need %h",
                         pr.kind, pr.inst, pr.cyc, act, pr.exp);
            end
        end

        if (done) begin
            compared++;
            if (req_q.size() != 0 || resp_q.size() != 0 ||
                probe_q.size() != 0) begin
                mismatched++;
                $display("FAIL leftover got req=%0d resp=%0d probe=%0d need 0 0 0",
                         req_q.size(), resp_q.size(), probe_q.size());
            end
            $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                     compared, mismatched);
            $finish;
        end
    end

    initial begin : guard
        #20000;
        $display("FAIL sim_timeout got no end need done");
        $fatal(1);
    end

endmodule
